aes_128: RTL and testbench

AES_128 -- requirements
Module: aes_128

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes_round.sv | 73 +++++++
 rtl/aes_128.sv | 64 ++++++
 tb/tb_aes_128.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte/word helpers: S-box, Rcon, GF(2^8) arithmetic,
// and the SubWord/RotWord primitives used by the on-the-fly key schedule.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NR      = 10;

  // Byte 0 of the table sits in the most significant bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon for rounds 1..10, round 1 in the most significant byte.
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [6:0] idx;
    idx = {3'b000, 4'd10 - round} << 3;
    return RCON[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One registered AES round: SubBytes, ShiftRows, optional MixColumns and AddRoundKey,
// with the next round key derived from the previous one in the same stage.
module aes_round
  import aes_pkg::*;
#(
  parameter int unsigned ROUND = 1,
  parameter bit          LAST  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] key_in,
  output logic [BLOCK_W-1:0] state_out,
  output logic [BLOCK_W-1:0] key_out
);

  function automatic logic [BLOCK_W-1:0] next_key(input logic [BLOCK_W-1:0] k,
                                                  input logic [7:0] rc);
    logic [WORD_W-1:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte (c,row) of the result comes from column (c+row)%4 of the same row.
  function automatic logic [BLOCK_W-1:0] sub_shift(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(15-(4*c+row)) +: 8] = sbox(s[8*(15-(4*((c+row)%4)+row)) +: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] mix_col(input logic [WORD_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  logic [BLOCK_W-1:0] key_c;
  logic [BLOCK_W-1:0] state_c;

  always_comb begin
    key_c   = next_key(key_in, rcon(4'(ROUND)));
    state_c = sub_shift(state_in);
    if (!LAST) state_c = mix_columns(state_c);
    state_c = state_c ^ key_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_out <= '0;
      key_out   <= '0;
    end else begin
      state_out <= state_c;
      key_out   <= key_c;
    end
  end

endmodule

// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryptor: one block per cycle, result 11 edges after sampling.
// Stage 0 registers the initial AddRoundKey; ten aes_round stages follow.
module aes_128
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] inp_data_0,
  input  logic [WORD_W-1:0] inp_data_1,
  input  logic [WORD_W-1:0] inp_data_2,
  input  logic [WORD_W-1:0] inp_data_3,
  input  logic [WORD_W-1:0] inp_key_0,
  input  logic [WORD_W-1:0] inp_key_1,
  input  logic [WORD_W-1:0] inp_key_2,
  input  logic [WORD_W-1:0] inp_key_3,
  output logic [WORD_W-1:0] out_data_0,
  output logic [WORD_W-1:0] out_data_1,
  output logic [WORD_W-1:0] out_data_2,
  output logic [WORD_W-1:0] out_data_3
);

  logic [BLOCK_W-1:0] block_c;
  logic [BLOCK_W-1:0] key_c;
  logic [BLOCK_W-1:0] s0_state;
  logic [BLOCK_W-1:0] s0_key;
  logic [BLOCK_W-1:0] stage_state [0:NR];
  logic [BLOCK_W-1:0] stage_key   [0:NR];

  assign block_c = {inp_data_3, inp_data_2, inp_data_1, inp_data_0};
  assign key_c   = {inp_key_3, inp_key_2, inp_key_1, inp_key_0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_state <= '0;
      s0_key   <= '0;
    end else begin
      s0_state <= block_c ^ key_c;
      s0_key   <= key_c;
    end
  end

  assign stage_state[0] = s0_state;
  assign stage_key[0]   = s0_key;

  for (genvar r = 1; r <= NR; r++) begin : g_round
    aes_round #(
      .ROUND(r),
      .LAST (r == NR)
    ) u_round (
      .clk      (clk),
      .reset    (reset),
      .state_in (stage_state[r-1]),
      .key_in   (stage_key[r-1]),
      .state_out(stage_state[r]),
      .key_out  (stage_key[r])
    );
  end

  assign out_data_3 = stage_state[NR][127:96];
  assign out_data_2 = stage_state[NR][95:64];
  assign out_data_1 = stage_state[NR][63:32];
  assign out_data_0 = stage_state[NR][31:0];

endmodule

// File: tb/tb_aes_128.sv
// Scoreboard bench for aes_128: random and known-answer blocks streamed every cycle,
// expected ciphertexts from a from-scratch GF(2^8) AES model, reset flush behaviour.
module tb_aes_128;

  logic        clk;
  logic        reset;
  logic [31:0] inp_data_0, inp_data_1, inp_data_2, inp_data_3;
  logic [31:0] inp_key_0, inp_key_1, inp_key_2, inp_key_3;
  logic [31:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [127:0] dout;

  typedef struct {
    logic [127:0] exp;
    int           due;
    int           tag;
  } sb_t;

  sb_t        sb_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb [256];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P3 = 128'h4142434445464748494a4b4c4d4e4f43;

  aes_128 dut (
    .clk       (clk),
    .reset     (reset),
    .inp_data_0(inp_data_0),
    .inp_data_1(inp_data_1),
    .inp_data_2(inp_data_2),
    .inp_data_3(inp_data_3),
    .inp_key_0 (inp_key_0),
    .inp_key_1 (inp_key_1),
    .inp_key_2 (inp_key_2),
    .inp_key_3 (inp_key_3),
    .out_data_0(out_data_0),
    .out_data_1(out_data_1),
    .out_data_2(out_data_2),
    .out_data_3(out_data_3)
  );

  assign dout = {out_data_3, out_data_2, out_data_1, out_data_0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sb[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) st[4*c+row] = tmp[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = st[4*c+j];
          for (int j = 0; j < 4; j++)
            st[4*c+j] = gf_mul(8'h02, a[j]) ^ gf_mul(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic [127:0] pt, input logic [127:0] key);
    {inp_data_3, inp_data_2, inp_data_1, inp_data_0} = pt;
    {inp_key_3, inp_key_2, inp_key_1, inp_key_0}     = key;
  endtask

  task automatic push(input logic [127:0] exp, input int due, input int tag);
    sb_t e;
    e.exp = exp;
    e.due = due;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: zero while in reset, otherwise compare against the entry due this edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("reset_zero", dout, 128'h0);
      end else if (sb_q.size() > 0) begin
        if (sb_q[0].due == cyc) begin
          e = sb_q.pop_front();
          check($sformatf("block_%0d", e.tag), dout, e.exp);
        end else if (sb_q[0].due < cyc) begin
          e = sb_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missed_block_%0d: due edge %0d, now edge %0d", e.tag, e.due, cyc);
        end
      end
    end
  end

  initial begin
    logic [127:0] pt, key, exp, exp3;
    reset = 1'b1;
    drive(128'h0, 128'h0);
    build_sbox();
    exp3 = aes_ref(P3, K1);
    repeat (3) @(negedge clk);

    // Back-to-back stream with inputs glitched between edges.
    for (int i = 0; i < 25; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #2 drive(rand128(), rand128());
      end
      @(negedge clk);
      if (i == 0) begin
        reset = 1'b0;
        push(C0, cyc + 10, 1000);
      end
      case (i)
        0:       begin pt = 128'h0; key = 128'h0; exp = C0; end
        5, 12:   begin pt = P1; key = K1; exp = C1; end
        6:       begin pt = P2; key = K2; exp = C2; end
        default: begin pt = rand128(); key = rand128(); exp = aes_ref(pt, key); end
      endcase
      drive(pt, key);
      push(exp, cyc + 11, i);
    end

    // Mid-stream reset: outputs clear without a clock edge and in-flight blocks vanish.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", dout, 128'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);

    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) begin
        reset = 1'b0;
        push(C0, cyc + 10, 1001);
      end
      drive(P3, K1);
      push(exp3, cyc + 11, 100 + k);
    end

    for (int k = 0; k < 40 && sb_q.size() > 0; k++) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
